filter_frame_streamer: RTL and testbench

- Reader side of the filter output frame. On `start`, it snapshots the parallel `filter_image` array produced by the convolution filter top.
- It then streams the snapshot out one 8-bit sample per beat over a valid/ready interface, with start-of-frame and end-of-frame markers.
- Downstream display and capture logic consumes pixels serially and never sees the full parallel array.

---
 rtl/filter_pkg.sv | 20 ++
 rtl/filter_frame_streamer_if.sv | 28 ++
 rtl/filter_frame_streamer_counter.sv | 82 ++++++++
 rtl/filter_frame_streamer.sv | 139 +++++++++++++
 tb/tb_filter_frame_streamer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared types, constants and sizing helper for the filter frame streamer slice.
package filter_pkg;

  typedef logic [7:0] pixel_t;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } stream_state_t;

  // Index width for an extent of n, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filter_frame_streamer_if.sv
// Serial pixel stream (valid/ready) carrying one sample plus its indices and frame markers.
interface filter_frame_streamer_if #(
  parameter int unsigned HoriPixel  = 4,
  parameter int unsigned VertiPixel = 4
);
  localparam int unsigned HW = filter_pkg::idx_w(HoriPixel);
  localparam int unsigned VW = filter_pkg::idx_w(VertiPixel);

  filter_pkg::pixel_t           pix_data;
  logic [filter_pkg::CH_W-1:0]  pix_ch;
  logic [HW-1:0]                pix_h;
  logic [VW-1:0]                pix_v;
  logic                         pix_sof;
  logic                         pix_eof;
  logic                         pix_valid;
  logic                         pix_ready;

  modport master (
    output pix_data, pix_ch, pix_h, pix_v, pix_sof, pix_eof, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_ch, pix_h, pix_v, pix_sof, pix_eof, pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/filter_frame_streamer_counter.sv
// Nested ch (innermost) / v / h (outermost) beat counters with look-ahead first/last flags.
module frame_index_counter
  import filter_pkg::*;
#(
  parameter int unsigned HoriPixel  = 4,
  parameter int unsigned VertiPixel = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_clear,
  input  logic                             i_advance,
  output logic [CH_W-1:0]                  o_ch,
  output logic [idx_w(HoriPixel)-1:0]      o_h,
  output logic [idx_w(VertiPixel)-1:0]     o_v,
  output logic [CH_W-1:0]                  o_nxt_ch_c,
  output logic [idx_w(HoriPixel)-1:0]      o_nxt_h_c,
  output logic [idx_w(VertiPixel)-1:0]     o_nxt_v_c,
  output logic                             o_nxt_first_c,
  output logic                             o_nxt_last_c
);

  localparam int unsigned HW = idx_w(HoriPixel);
  localparam int unsigned VW = idx_w(VertiPixel);

  localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);
  localparam logic [HW-1:0]   H_MAX  = HW'(HoriPixel - 1);
  localparam logic [VW-1:0]   V_MAX  = VW'(VertiPixel - 1);

  logic [CH_W-1:0] r_ch;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;

  logic [CH_W-1:0] w_nxt_ch;
  logic [HW-1:0]   w_nxt_h;
  logic [VW-1:0]   w_nxt_v;

  // Next index: clear wins, otherwise ch carries into v, v carries into h.
  always_comb begin
    w_nxt_ch = r_ch;
    w_nxt_h  = r_h;
    w_nxt_v  = r_v;
    if (i_clear) begin
      w_nxt_ch = '0;
      w_nxt_h  = '0;
      w_nxt_v  = '0;
    end else if (i_advance) begin
      if (r_ch == CH_MAX) begin
        w_nxt_ch = '0;
        if (r_v == V_MAX) begin
          w_nxt_v = '0;
          w_nxt_h = (r_h == H_MAX) ? '0 : r_h + HW'(1);
        end else begin
          w_nxt_v = r_v + VW'(1);
        end
      end else begin
        w_nxt_ch = r_ch + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch <= '0;
      r_h  <= '0;
      r_v  <= '0;
    end else begin
      r_ch <= w_nxt_ch;
      r_h  <= w_nxt_h;
      r_v  <= w_nxt_v;
    end
  end

  assign o_ch          = r_ch;
  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_nxt_ch_c    = w_nxt_ch;
  assign o_nxt_h_c     = w_nxt_h;
  assign o_nxt_v_c     = w_nxt_v;
  assign o_nxt_first_c = (w_nxt_ch == '0) && (w_nxt_h == '0) && (w_nxt_v == '0);
  assign o_nxt_last_c  = (w_nxt_ch == CH_MAX) && (w_nxt_h == H_MAX) && (w_nxt_v == V_MAX);

endmodule

// File: rtl/filter_frame_streamer.sv
// Captures the parallel filter image on start and streams it out one sample per beat.
module filter_frame_streamer
  import filter_pkg::*;
#(
  parameter int unsigned HoriPixel  = 4,
  parameter int unsigned VertiPixel = 4
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  pixel_t [0:NUM_CH-1][0:HoriPixel-1][0:VertiPixel-1]    frame,
  output logic                                                  busy,
  output logic                                                  done,
  filter_frame_streamer_if.master                               pix
);

  localparam int unsigned HW = idx_w(HoriPixel);
  localparam int unsigned VW = idx_w(VertiPixel);

  stream_state_t r_state;
  stream_state_t w_nxt_state;

  pixel_t [0:NUM_CH-1][0:HoriPixel-1][0:VertiPixel-1] r_buf;

  pixel_t r_data;
  logic   r_valid;
  logic   r_busy;
  logic   r_done;
  logic   r_sof;
  logic   r_eof;

  logic w_load;
  logic w_adv;

  logic [CH_W-1:0] w_ch;
  logic [HW-1:0]   w_h;
  logic [VW-1:0]   w_v;
  logic [CH_W-1:0] w_nxt_ch;
  logic [HW-1:0]   w_nxt_h;
  logic [VW-1:0]   w_nxt_v;
  logic            w_nxt_first;
  logic            w_nxt_last;

  frame_index_counter #(
    .HoriPixel  (HoriPixel),
    .VertiPixel (VertiPixel)
  ) u_idx (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_load),
    .i_advance     (w_adv),
    .o_ch          (w_ch),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_nxt_ch_c    (w_nxt_ch),
    .o_nxt_h_c     (w_nxt_h),
    .o_nxt_v_c     (w_nxt_v),
    .o_nxt_first_c (w_nxt_first),
    .o_nxt_last_c  (w_nxt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Start is only honoured in IDLE; DONE always falls back to IDLE for one cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_state = SEND;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (pix.pix_ready) begin
          w_adv = 1'b1;
          if (r_eof) begin
            w_nxt_state = DONE;
          end
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Snapshot storage; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_buf <= frame;
    end
  end

  // Outputs are precomputed from the next state and next indices so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= (w_nxt_state == SEND);
      r_busy  <= (w_nxt_state == SEND);
      r_done  <= (w_nxt_state == DONE);
      r_sof   <= (w_nxt_state == SEND) && w_nxt_first;
      r_eof   <= (w_nxt_state == SEND) && w_nxt_last;
      if (w_load) begin
        r_data <= frame[0][0][0];
      end else if (w_adv) begin
        r_data <= r_buf[w_nxt_ch][w_nxt_h][w_nxt_v];
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pix.pix_data  = r_data;
  assign pix.pix_ch    = w_ch;
  assign pix.pix_h     = w_h;
  assign pix.pix_v     = w_v;
  assign pix.pix_sof   = r_sof;
  assign pix.pix_eof   = r_eof;
  assign pix.pix_valid = r_valid;

endmodule

// File: tb/tb_filter_frame_streamer.sv
// Scoreboard bench for filter_frame_streamer: 4x4 build plus a 1x1 degenerate build.
module tb_filter_frame_streamer;
  import filter_pkg::*;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 4;
  localparam int unsigned NB = 3 * H * V;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
    logic [1:0] h;
    logic [1:0] v;
    logic       sof;
    logic       eof;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic   start4 = 1'b0;
  logic   start1 = 1'b0;
  logic   rdy4   = 1'b1;
  logic   rdy1   = 1'b1;
  logic   rmode  = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  pixel_t [0:2][0:H-1][0:V-1] frame4;
  pixel_t [0:2][0:0][0:0]     frame1;
  logic busy4, done4, busy1, done1;

  filter_frame_streamer_if #(.HoriPixel(H), .VertiPixel(V)) p4 ();
  filter_frame_streamer_if #(.HoriPixel(1), .VertiPixel(1)) p1 ();
  assign p4.pix_ready = rdy4;
  assign p1.pix_ready = rdy1;

  filter_frame_streamer #(.HoriPixel(H), .VertiPixel(V)) dut4 (
    .clk(clk), .reset(rst_n), .start(start4), .frame(frame4),
    .busy(busy4), .done(done4), .pix(p4)
  );

  filter_frame_streamer #(.HoriPixel(1), .VertiPixel(1)) dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .frame(frame1),
    .busy(busy1), .done(done1), .pix(p1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rx4 = 0;
  int last_eof_cyc = -10;
  int done_cyc = -10;
  bit chk_restart = 1'b0;
  beat_t q4[$];
  beat_t q1[$];

  function automatic void chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic void check_beat(input string nm, input beat_t got, input beat_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got d=%h c=%0d h=%0d v=%0d sof=%b eof=%b expected d=%h c=%0d h=%0d v=%0d sof=%b eof=%b (t=%0t)",
               nm, got.data, got.ch, got.h, got.v, got.sof, got.eof,
               exp.data, exp.ch, exp.h, exp.v, exp.sof, exp.eof, $time);
    end
  endfunction

  function automatic logic [7:0] pat(input int c, input int h, input int v);
    return 8'(16 * c + 4 * h + v);
  endfunction

  always @(posedge clk) cyc++;

  // Ready driver: tied high or pseudo-random, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rmode) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rdy4 = lfsr[0];
    end else begin
      rdy4 = 1'b1;
    end
  end

  // Monitor for the 4x4 build; stalled beats are checked against the head without popping.
  always @(negedge clk) begin
    beat_t got;
    if (p4.pix_valid === 1'b1) begin
      got = '{p4.pix_data, p4.pix_ch, p4.pix_h, p4.pix_v, p4.pix_sof, p4.pix_eof};
      if (q4.size() == 0) begin
        chk("unexpected_beat4", 1, 0);
      end else begin
        check_beat(p4.pix_ready ? "beat4" : "stall4", got, q4[0]);
        if (p4.pix_ready) begin
          void'(q4.pop_front());
          rx4++;
          if (got.eof) last_eof_cyc = cyc;
        end
      end
      if (chk_restart && got.sof && done_cyc >= 0) chk("restart_gap", cyc - done_cyc, 2);
    end
    if (done4 === 1'b1) begin
      chk("done_latency", cyc, last_eof_cyc + 1);
      chk("done_busy", int'(busy4), 0);
      chk("done_valid", int'(p4.pix_valid), 0);
      done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    beat_t got;
    if (p1.pix_valid === 1'b1) begin
      got = '{p1.pix_data, p1.pix_ch, 2'(p1.pix_h), 2'(p1.pix_v), p1.pix_sof, p1.pix_eof};
      if (q1.size() == 0) chk("unexpected_beat1", 1, 0);
      else begin
        check_beat("beat1", got, q1[0]);
        if (p1.pix_ready) void'(q1.pop_front());
      end
    end
    if (done1 === 1'b1) begin
      chk("done1_busy", int'(busy1), 0);
      chk("done1_qempty", q1.size(), 0);
    end
  end

  task automatic push_frame4();
    int idx = 0;
    for (int h = 0; h < int'(H); h++)
      for (int v = 0; v < int'(V); v++)
        for (int c = 0; c < 3; c++) begin
          q4.push_back(beat_t'{pat(c, h, v), 2'(c), 2'(h), 2'(v), idx == 0, idx == int'(NB) - 1});
          idx++;
        end
  endtask

  task automatic load_pattern4();
    for (int c = 0; c < 3; c++)
      for (int h = 0; h < int'(H); h++)
        for (int v = 0; v < int'(V); v++)
          frame4[c][h][v] = pat(c, h, v);
  endtask

  task automatic pulse_start4();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
  endtask

  task automatic wait_done4(input string nm, input int budget);
    int n = 0;
    while (done4 !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(nm, int'(done4 === 1'b1), 1);
  endtask

  initial begin
    int n;
    load_pattern4();
    frame1 = '0;

    // Reset state
    #12;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_valid", int'(p4.pix_valid), 0);
    chk("rst_sof", int'(p4.pix_sof), 0);
    chk("rst_eof", int'(p4.pix_eof), 0);
    chk("rst_data", int'(p4.pix_data), 0);
    chk("rst_idx", int'({p4.pix_ch, p4.pix_h, p4.pix_v}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame, ready tied high
    push_frame4();
    pulse_start4();
    wait_done4("t1_done", 200);
    chk("t1_qempty", q4.size(), 0);

    // Same frame with pseudo-random backpressure
    repeat (3) @(negedge clk);
    rmode = 1'b1;
    push_frame4();
    pulse_start4();
    wait_done4("t2_done", 1000);
    chk("t2_qempty", q4.size(), 0);
    rmode = 1'b0;

    // Input frame overwritten right after capture
    repeat (3) @(negedge clk);
    push_frame4();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; frame4 = '1;
    wait_done4("t3_done", 200);
    chk("t3_qempty", q4.size(), 0);
    load_pattern4();

    // Start held high: one frame per IDLE visit, second sof two cycles after done
    repeat (3) @(negedge clk);
    done_cyc = -10;
    chk_restart = 1'b1;
    push_frame4();
    push_frame4();
    n = rx4;
    @(negedge clk); start4 = 1'b1;
    for (int i = 0; i < 300 && rx4 < n + int'(NB) + 1; i++) @(negedge clk);
    start4 = 1'b0;
    chk("t4_second_started", int'(rx4 >= n + int'(NB) + 1), 1);
    wait_done4("t4_done", 200);
    repeat (6) @(negedge clk);
    chk("t4_qempty", q4.size(), 0);
    chk_restart = 1'b0;

    // Reset asserted while beat 20 is presented
    push_frame4();
    n = rx4;
    pulse_start4();
    for (int i = 0; i < 200 && rx4 < n + 20; i++) begin
      @(negedge clk); #1;
    end
    chk("t5_reached20", int'(rx4 >= n + 20), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", int'(p4.pix_valid), 0);
    chk("t5_busy", int'(busy4), 0);
    chk("t5_done", int'(done4), 0);
    q4.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle_valid", int'(p4.pix_valid), 0);
    push_frame4();
    pulse_start4();
    wait_done4("t5_done_after", 200);
    chk("t5_qempty", q4.size(), 0);

    // Degenerate 1x1 build
    frame1[0][0][0] = 8'h11;
    frame1[1][0][0] = 8'h22;
    frame1[2][0][0] = 8'h33;
    q1.push_back(beat_t'{8'h11, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0});
    q1.push_back(beat_t'{8'h22, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0});
    q1.push_back(beat_t'{8'h33, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1});
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("t6_done", int'(done1 === 1'b1), 1);
    repeat (3) @(negedge clk);
    chk("t6_qempty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
